hazard_controller: RTL and testbench

Pipeline interlock and forwarding-select controller for the 5-stage MIPS core. Tracks destination tags of instructions in EXE, MEM and WB, and compares them against the ID-stage source operands. Drives the per-operand hazard flags consumed by the ID-stage forwarding mux. Stalls IF/ID and injects EXE bubbles for load-use and multiply/divide (HI/LO) interlocks.

---
 rtl/hazard_controller_if.sv | 56 +++++
 rtl/hazard_controller.sv | 144 ++++++++++++++
 tb/tb_hazard_controller.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// ID-stage operand/hazard bundle between the decode stage and hazard_controller.
// master = decode side, slave = hazard_controller.
interface hazard_controller_if;
  logic       mem_stall;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       id_is_store;
  logic       id_writes_reg;
  logic [4:0] id_dest;
  logic       id_is_load;
  logic       id_is_muldiv;
  logic       id_uses_hilo;
  logic       id_flush;
  logic       stall_if_id;
  logic       bubble_ex;
  logic       has_reg1_hazard;
  logic       has_reg2_hazard;
  logic       has_saved_val_hazard;
  logic       is_reg1_EXE_hazard;
  logic       is_reg1_MEM_hazard;
  logic       is_reg1_WB_hazard;
  logic       is_reg2_EXE_hazard;
  logic       is_reg2_MEM_hazard;
  logic       is_reg2_WB_hazard;

  modport master (
    output mem_stall, id_valid, id_rs, id_rt,
    output id_uses_rs, id_uses_rt, id_is_store,
    output id_writes_reg, id_dest, id_is_load,
    output id_is_muldiv, id_uses_hilo, id_flush,
    input  stall_if_id, bubble_ex,
    input  has_reg1_hazard, has_reg2_hazard,
    input  has_saved_val_hazard,
    input  is_reg1_EXE_hazard, is_reg1_MEM_hazard,
    input  is_reg1_WB_hazard,
    input  is_reg2_EXE_hazard, is_reg2_MEM_hazard,
    input  is_reg2_WB_hazard
  );

  modport slave (
    input  mem_stall, id_valid, id_rs, id_rt,
    input  id_uses_rs, id_uses_rt, id_is_store,
    input  id_writes_reg, id_dest, id_is_load,
    input  id_is_muldiv, id_uses_hilo, id_flush,
    output stall_if_id, bubble_ex,
    output has_reg1_hazard, has_reg2_hazard,
    output has_saved_val_hazard,
    output is_reg1_EXE_hazard, is_reg1_MEM_hazard,
    output is_reg1_WB_hazard,
    output is_reg2_EXE_hazard, is_reg2_MEM_hazard,
    output is_reg2_WB_hazard
  );
endinterface

// File: rtl/hazard_controller.sv
// Interlock and forwarding-select controller for the 5-stage MIPS pipeline.
// HAZARD_MULDIV_EN enables the HI/LO busy counter and its interlock.
module hazard_controller #(
  parameter int MULDIV_LATENCY = 4
) (
  input logic                clk,
  input logic                rst,
  hazard_controller_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic       writes;
    logic [4:0] dest;
    logic       is_load;
  } tag_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LDUSE,
    ST_HILO_WAIT
  } state_t;

  tag_t   r_exe, r_mem, r_wb;
  state_t r_state, w_state_nxt;

  logic w_r1_e, w_r1_m, w_r1_w;
  logic w_r2_e, w_r2_m, w_r2_w;
  logic w_any_rs, w_any_rt;
  logic w_load_use, w_hilo_block;
  logic w_stall, w_issue, w_busy_nz;

  function automatic logic f_hit(tag_t t, logic [4:0] r);
    return t.valid && t.writes &&
           (t.dest == r) && (r != 5'd0);
  endfunction

  assign w_r1_e = f_hit(r_exe, bus.id_rs);
  assign w_r1_m = f_hit(r_mem, bus.id_rs);
  assign w_r1_w = f_hit(r_wb,  bus.id_rs);
  assign w_r2_e = f_hit(r_exe, bus.id_rt);
  assign w_r2_m = f_hit(r_mem, bus.id_rt);
  assign w_r2_w = f_hit(r_wb,  bus.id_rt);

  assign w_any_rs = w_r1_e | w_r1_m | w_r1_w;
  assign w_any_rt = w_r2_e | w_r2_m | w_r2_w;

  // Only a load still in EXE stalls; MEM/WB loads are forwarded.
  assign w_load_use = bus.id_valid && r_exe.valid &&
    r_exe.is_load && (r_exe.dest != 5'd0) &&
    ((bus.id_uses_rs && (r_exe.dest == bus.id_rs)) ||
     ((bus.id_uses_rt || bus.id_is_store) &&
      (r_exe.dest == bus.id_rt)));

`ifdef HAZARD_MULDIV_EN
  localparam int CW = $clog2(MULDIV_LATENCY + 1);

  logic [CW-1:0] r_busy;

  assign w_busy_nz    = (r_busy != '0);
  assign w_hilo_block = bus.id_valid && w_busy_nz &&
    (bus.id_uses_hilo || bus.id_is_muldiv);

  // Counts down even while memory stalls: HI/LO keeps computing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else if (!bus.mem_stall && w_issue &&
                 bus.id_is_muldiv) begin
      r_busy <= CW'(MULDIV_LATENCY);
    end else if (w_busy_nz) begin
      r_busy <= r_busy - CW'(1);
    end
  end
`else
  localparam int lp_unused_lat = MULDIV_LATENCY;
  logic w_unused_hilo;

  assign w_unused_hilo = bus.id_is_muldiv ^ bus.id_uses_hilo;
  assign w_busy_nz     = 1'b0;
  assign w_hilo_block  = 1'b0;
`endif

  assign w_stall = w_load_use || w_hilo_block;
  assign w_issue = bus.id_valid && !w_stall && !bus.id_flush;

  assign bus.stall_if_id = w_stall || bus.mem_stall;
  assign bus.bubble_ex   = w_stall && !bus.mem_stall;

  assign bus.has_reg1_hazard =
    bus.id_valid && bus.id_uses_rs && w_any_rs;
  assign bus.has_reg2_hazard =
    bus.id_valid && bus.id_uses_rt && w_any_rt;
  assign bus.has_saved_val_hazard =
    bus.id_valid && bus.id_is_store && w_any_rt;

  assign bus.is_reg1_EXE_hazard = w_r1_e;
  assign bus.is_reg1_MEM_hazard = w_r1_m;
  assign bus.is_reg1_WB_hazard  = w_r1_w;
  assign bus.is_reg2_EXE_hazard = w_r2_e;
  assign bus.is_reg2_MEM_hazard = w_r2_m;
  assign bus.is_reg2_WB_hazard  = w_r2_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exe <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!bus.mem_stall) begin
      r_wb          <= r_mem;
      r_mem         <= r_exe;
      r_exe.valid   <= w_issue;
      r_exe.writes  <= bus.id_writes_reg;
      r_exe.dest    <= bus.id_dest;
      r_exe.is_load <= bus.id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN: begin
        if (w_load_use) begin
          if (!bus.mem_stall) w_state_nxt = ST_LDUSE;
        end else if (w_hilo_block) begin
          w_state_nxt = ST_HILO_WAIT;
        end
      end
      ST_LDUSE: begin
        if (!bus.mem_stall) w_state_nxt = ST_RUN;
      end
      ST_HILO_WAIT: begin
        if (!w_busy_nz) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed vector table, corner sequences,
// and random stimulus against a pipeline-history reference model.
module tb_hazard_controller;

  localparam int LAT = 4;
`ifdef HAZARD_MULDIV_EN
  localparam int EXP_STALLS = LAT;
`else
  localparam int EXP_STALLS = 0;
`endif
  localparam logic [10:0] SB = 11'b11000000000;
  localparam logic [10:0] HW = (EXP_STALLS > 0) ? SB : 11'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hazard_controller_if bus ();

  hazard_controller #(.MULDIV_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst, ms, v;
    bit [4:0] rs, rt;
    bit       urs, urt, st, wr;
    bit [4:0] dst;
    bit       ld, md, hl, fl;
  } in_t;

  typedef struct {
    in_t         i;
    logic [10:0] e;
    string       nm;
  } row_t;

  typedef struct {
    bit       valid, writes, ld;
    bit [4:0] dest;
  } ent_t;

  int n_chk = 0;
  int n_pass = 0;

  ent_t pipe [3];
  bit   mul_seen;
  int   ecyc, mul_edge;
  row_t tbl [$];

  function automatic in_t mi(bit v, bit [4:0] rs, bit urs,
                             bit [4:0] rt, bit urt, bit st,
                             bit wr, bit [4:0] dst, bit ld);
    in_t x;
    x = '{default: '0};
    x.v = v; x.rs = rs; x.urs = urs; x.rt = rt; x.urt = urt;
    x.st = st; x.wr = wr; x.dst = dst; x.ld = ld;
    return x;
  endfunction

  function automatic in_t frst(in_t x); x.rst = 1; return x; endfunction
  function automatic in_t fms(in_t x);  x.ms = 1;  return x; endfunction
  function automatic in_t ffl(in_t x);  x.fl = 1;  return x; endfunction
  function automatic in_t fmd(in_t x);  x.md = 1;  return x; endfunction
  function automatic in_t fhl(in_t x);  x.hl = 1;  return x; endfunction

  task automatic add(in_t x, logic [10:0] e, string nm);
    row_t r;
    r.i = x; r.e = e; r.nm = nm;
    tbl.push_back(r);
  endtask

  function automatic bit m_hilo_busy();
    return mul_seen && ((ecyc - mul_edge) < LAT);
  endfunction

  function automatic bit m_stall(in_t x);
    bit lu, hb;
    lu = x.v && pipe[0].valid && pipe[0].ld && pipe[0].dest != 0 &&
         ((x.urs && pipe[0].dest == x.rs) ||
          ((x.urt || x.st) && pipe[0].dest == x.rt));
    hb = 0;
`ifdef HAZARD_MULDIV_EN
    hb = x.v && (x.hl || x.md) && m_hilo_busy();
`endif
    return lu || hb;
  endfunction

  function automatic logic [10:0] m_out(in_t x);
    bit [2:0] m1, m2;
    bit s;
    for (int k = 0; k < 3; k++) begin
      m1[2-k] = pipe[k].valid && pipe[k].writes &&
                pipe[k].dest == x.rs && x.rs != 0;
      m2[2-k] = pipe[k].valid && pipe[k].writes &&
                pipe[k].dest == x.rt && x.rt != 0;
    end
    s = m_stall(x);
    return {s || x.ms, s && !x.ms,
            x.v && x.urs && (|m1), x.v && x.urt && (|m2),
            x.v && x.st && (|m2), m1, m2};
  endfunction

  task automatic m_edge(in_t x);
    ent_t n;
    bit s;
    s = m_stall(x);
    if (x.rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = '{default: '0};
      mul_seen = 0;
    end else begin
      ecyc++;
      if (!x.ms) begin
        n.valid = x.v && !s && !x.fl;
        n.writes = x.wr; n.dest = x.dst; n.ld = x.ld;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = n;
`ifdef HAZARD_MULDIV_EN
        if (n.valid && x.md) begin
          mul_seen = 1;
          mul_edge = ecyc;
        end
`endif
      end
    end
  endtask

  function automatic logic [10:0] dut_out();
    return {bus.stall_if_id, bus.bubble_ex,
            bus.has_reg1_hazard, bus.has_reg2_hazard,
            bus.has_saved_val_hazard,
            bus.is_reg1_EXE_hazard, bus.is_reg1_MEM_hazard,
            bus.is_reg1_WB_hazard,
            bus.is_reg2_EXE_hazard, bus.is_reg2_MEM_hazard,
            bus.is_reg2_WB_hazard};
  endfunction

  task automatic apply(in_t x, logic [10:0] e, string nm);
    logic [10:0] got;
    rst               = x.rst;
    bus.mem_stall     = x.ms;
    bus.id_valid      = x.v;
    bus.id_rs         = x.rs;
    bus.id_rt         = x.rt;
    bus.id_uses_rs    = x.urs;
    bus.id_uses_rt    = x.urt;
    bus.id_is_store   = x.st;
    bus.id_writes_reg = x.wr;
    bus.id_dest       = x.dst;
    bus.id_is_load    = x.ld;
    bus.id_is_muldiv  = x.md;
    bus.id_uses_hilo  = x.hl;
    bus.id_flush      = x.fl;
    @(negedge clk);
    got = dut_out();
    n_chk++;
    if (got === e) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, got, e);
    m_edge(x);
    @(posedge clk);
    #1;
  endtask

  in_t idle, add3, sub_r3, rd3, lw5, use5, lw0, rd0, add7, sw7;
  in_t ld_rs5, fl_w10, rd10, mult, mfhi, x;

  initial begin
    for (int k = 0; k < 3; k++) pipe[k] = '{default: '0};
    mul_seen = 0; ecyc = 0; mul_edge = 0;

    idle   = mi(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add3   = mi(1, 1, 1, 2, 1, 0, 1, 3, 0);
    sub_r3 = mi(1, 3, 1, 4, 1, 0, 1, 6, 0);
    rd3    = mi(1, 3, 1, 0, 0, 0, 0, 0, 0);
    lw5    = mi(1, 0, 1, 5, 0, 0, 1, 5, 1);
    use5   = mi(1, 1, 1, 5, 1, 0, 1, 8, 0);
    lw0    = mi(1, 0, 1, 0, 0, 0, 1, 0, 1);
    rd0    = mi(1, 0, 1, 0, 1, 0, 1, 9, 0);
    add7   = mi(1, 1, 1, 2, 1, 0, 1, 7, 0);
    sw7    = mi(1, 1, 1, 7, 0, 1, 0, 0, 0);
    ld_rs5 = mi(1, 5, 1, 2, 1, 0, 1, 8, 0);
    fl_w10 = ffl(mi(1, 8, 1, 0, 0, 0, 1, 10, 0));
    rd10   = mi(1, 10, 1, 0, 0, 0, 0, 0, 0);
    mult   = fmd(mi(1, 1, 1, 2, 1, 0, 0, 0, 0));
    mfhi   = fhl(mi(1, 0, 0, 0, 0, 0, 1, 3, 0));

    add(frst(idle), 11'b00000000000, "reset");
    add(idle,       11'b00000000000, "idle");
    add(add3,       11'b00000000000, "add3");
    add(sub_r3,     11'b00100100000, "alu_exe");
    add(rd3,        11'b00100010000, "alu_mem");
    add(mi(0, 3, 1, 3, 1, 0, 0, 0, 0),
                    11'b00000001001, "alu_wb_raw");
    add(lw5,        11'b00000000000, "lw5");
    add(use5,       11'b11010000100, "ldu_stall");
    add(use5,       11'b00010000010, "ldu_mem");
    add(lw0,        11'b00000000000, "lw0");
    add(rd0,        11'b00000000000, "r0_read");
    add(add7,       11'b00000000000, "add7");
    add(sw7,        11'b00001000100, "store_fwd");
    add(idle,       11'b00000000000, "idle2");
    add(idle,       11'b00000000000, "idle3");
    add(lw5,        11'b00000000000, "lw5b");
    add(fms(ld_rs5),11'b10100100000, "ms_hold1");
    add(fms(ld_rs5),11'b10100100000, "ms_hold2");
    add(fms(ld_rs5),11'b10100100000, "ms_hold3");
    add(ld_rs5,     11'b11100100000, "ms_bubble");
    add(ld_rs5,     11'b00100010000, "ms_after");
    add(fl_w10,     11'b00100100000, "flush_raw");
    add(rd10,       11'b00000000000, "flush_gone");

    foreach (tbl[k]) apply(tbl[k].i, tbl[k].e, tbl[k].nm);

    apply(frst(idle), 11'b0, "mul_rst");
    apply(mult, 11'b0, "mult");
    for (int k = 0; k < EXP_STALLS; k++) apply(mfhi, SB, "hilo_stall");
    apply(mfhi, 11'b0, "hilo_issue");

    apply(mult, 11'b0, "mult2");
    apply(mfhi, HW, "hw_enter");
    apply(frst(mfhi), HW, "hw_rst");
    apply(idle, 11'b0, "hw_post_idle");
    apply(mfhi, 11'b0, "hw_post_mfhi");

    apply(ffl(mult), 11'b0, "flush_mult");
    apply(mfhi, 11'b0, "flush_no_busy");

    apply(lw5, 11'b0, "lw5c");
    apply(frst(use5), 11'b11010000100, "rst_ldu");
    apply(use5, 11'b0, "rst_ldu_after");

    apply(frst(idle), 11'b0, "rand_rst");
    for (int c = 0; c < 600; c++) begin
      x = '{default: '0};
      x.rst = ($urandom_range(63) == 0);
      x.ms  = ($urandom_range(4) == 0);
      x.v   = ($urandom_range(5) != 0);
      x.rs  = 5'($urandom_range(3));
      x.rt  = 5'($urandom_range(3));
      x.urs = 1'($urandom);
      x.urt = 1'($urandom);
      x.st  = ($urandom_range(3) == 0);
      x.wr  = 1'($urandom);
      x.dst = 5'($urandom_range(3));
      x.ld  = ($urandom_range(2) == 0);
      x.md  = ($urandom_range(5) == 0);
      x.hl  = ($urandom_range(3) == 0);
      x.fl  = ($urandom_range(7) == 0);
      apply(x, m_out(x), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
